adc_conversion_scheduler: RTL and testbench

Sequencer for the AD7685 ADC serial interface block. It issues conversion-start pulses at a programmable period or on single-shot request, and waits for each result with a timeout. It accumulates and averages 2^AVG_LOG2 results into one output word, and flags overruns and lost conversions. It sits between the ADC interface (driving its CNV_START, consuming BUSY/VALID/RESULT) and the downstream sample consumer.

---
 rtl/adc_conversion_scheduler_if.sv | 11 +
 rtl/adc_conversion_scheduler.sv | 133 +++++++++++++
 tb/tb_adc_conversion_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_conversion_scheduler_if.sv
// Handshake between the conversion scheduler and the AD7685 serial interface block.
// The scheduler issues cnv_start; the interface block returns busy, valid and result.
interface adc_conversion_scheduler_if;
  logic        cnv_start;
  logic        busy;
  logic        valid;
  logic [15:0] result;

  modport master (output cnv_start, input busy, valid, result);
  modport slave  (input cnv_start, output busy, valid, result);
endinterface

// File: rtl/adc_conversion_scheduler.sv
// Periodic/single-shot conversion sequencer for the AD7685 interface.
// Each result is awaited with a timeout, and 2^n results are averaged into one output word.
module adc_conversion_scheduler #(
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [2:0]          avg_log2,
  input  logic                single,
  input  logic                clr_err,
  adc_conversion_scheduler_if.master adc,
  output logic [15:0]         avg_data,
  output logic                avg_valid,
  output logic                active,
  output logic                overrun,
  output logic                timeout_err
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_next;

  logic [PERIOD_W-1:0] cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [22:0]         acc;
  logic [7:0]          count;
  logic [2:0]          avg_n;
  logic                cnv_start;

  logic        tick, trigger, launch, drop_tick, accept, timed_out, block_done;
  logic [22:0] sum, shifted;
  logic [7:0]  count_inc;

  assign tick       = enable && (cnt == '0);
  assign trigger    = enable ? tick : single;
  assign sum        = acc + {7'd0, adc.result};
  assign count_inc  = count + 8'd1;
  assign block_done = (count_inc == (8'd1 << avg_n));
  assign shifted    = sum >> avg_n;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A VALID in the last allowed cycle still wins over the timeout.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    drop_tick  = 1'b0;
    accept     = 1'b0;
    timed_out  = 1'b0;
    active     = 1'b0;
    case (state)
      IDLE: begin
        if (trigger) begin
          if (!adc.busy) begin
            launch     = 1'b1;
            state_next = WAIT;
          end else begin
            drop_tick = tick;
          end
        end
      end
      WAIT: begin
        active    = 1'b1;
        drop_tick = tick;
        if (adc.valid) begin
          accept     = 1'b1;
          state_next = IDLE;
        end else if (tmo_cnt == TMO_W'(TIMEOUT)) begin
          timed_out  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      tmo_cnt     <= '0;
      acc         <= '0;
      count       <= '0;
      avg_n       <= '0;
      cnv_start   <= 1'b0;
      avg_data    <= '0;
      avg_valid   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (!enable)         cnt <= '0;
      else if (cnt == '0)  cnt <= period;
      else                 cnt <= cnt - PERIOD_W'(1);

      cnv_start <= launch;
      avg_valid <= 1'b0;

      if (launch)             tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + TMO_W'(1);

      // Block size is frozen when the first conversion of a block is launched.
      if (launch && count == 8'd0) avg_n <= avg_log2;

      if (accept) begin
        if (block_done) begin
          avg_data  <= shifted[15:0];
          avg_valid <= 1'b1;
          acc       <= '0;
          count     <= '0;
        end else begin
          acc   <= sum;
          count <= count_inc;
        end
      end else if (timed_out) begin
        acc   <= '0;
        count <= '0;
      end

      if (drop_tick)    overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;

      if (timed_out)    timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

  assign adc.cnv_start = cnv_start;
endmodule

// File: tb/tb_adc_conversion_scheduler.sv
// Self-checking bench: behavioural ADC model, averaging scoreboard, vector table plus corner sequences.
module tb_adc_conversion_scheduler;
  localparam int TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        single = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] period = '0;
  logic [2:0]  avg_log2 = '0;
  logic [15:0] avg_data;
  logic        avg_valid, active, overrun, timeout_err;

  adc_conversion_scheduler_if adc();

  adc_conversion_scheduler #(.PERIOD_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period), .avg_log2(avg_log2),
    .single(single), .clr_err(clr_err), .adc(adc), .avg_data(avg_data),
    .avg_valid(avg_valid), .active(active), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]       n;
    logic [3:0][15:0] v;
    logic [15:0]      exp;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] sb_q[$];
  logic [15:0] results_q[$];
  int          start_cycles[$];
  int          avg_seen = 0;
  int          valid_delay = 10;
  bit          mute = 1'b0;
  bit          sb_auto = 1'b0;
  logic [15:0] default_result = 16'h1234;
  int          delay_cnt = 0;
  int          last_valid_cyc = -10;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic report_expired(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int b = 0;
    while (start_cycles.size() < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (start_cycles.size() < n) report_expired(name);
  endtask

  task automatic wait_avg(input int n, input int budget, input string name);
    int b = 0;
    while (avg_seen < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (avg_seen < n) report_expired(name);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick_n(1);
    clr_err = 1'b0;
    tick_n(1);
  endtask

  // ADC model: VALID with a result valid_delay cycles after each CNV_START, unless muted.
  always @(negedge clk) begin
    adc.valid = 1'b0;
    if (delay_cnt > 0) begin
      delay_cnt--;
      if (delay_cnt == 0) begin
        if (results_q.size() > 0) adc.result = results_q.pop_front();
        else                      adc.result = default_result;
        adc.valid = 1'b1;
        last_valid_cyc = cyc;
        if (sb_auto) sb_q.push_back(adc.result);
      end
    end
    if (adc.cnv_start && !mute) delay_cnt = valid_delay;
  end

  always @(negedge clk) begin
    if (adc.cnv_start) start_cycles.push_back(cyc);
    if (avg_valid) begin
      avg_seen++;
      check_output("avg_valid_latency", cyc, last_valid_cyc + 1);
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_avg_valid: got avg_data 0x%0h, expected no strobe (cycle %0d)", avg_data, cyc);
      end else begin
        check_output("avg_data", avg_data, sb_q.pop_front());
      end
    end
  end

  function automatic vec_t mk(input logic [2:0] n, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d, input logic [15:0] e);
    vec_t r;
    r.n = n;
    r.v[0] = a; r.v[1] = b; r.v[2] = c; r.v[3] = d;
    r.exp = e;
    return r;
  endfunction

  task automatic apply_stimulus(input vec_t vc);
    int total = 1 << vc.n;
    int seen0 = avg_seen;
    avg_log2 = vc.n;
    for (int i = 0; i < total; i++) results_q.push_back(vc.v[i[1:0]]);
    sb_q.push_back(vc.exp);
    enable = 1'b1;
    wait_avg(seen0 + 1, total * 40 + 100, "vector_avg_valid");
    enable = 1'b0;
    tick_n(5);
    check_output("vector_results_consumed", results_q.size(), 0);
    check_output("vector_scoreboard_empty", sb_q.size(), 0);
    results_q.delete();
    sb_q.delete();
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    int   e, s, t, seen0;

    vecs[0] = mk(3'd0, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h1234);
    vecs[1] = mk(3'd2, 16'h0001, 16'h0002, 16'h0003, 16'h0006, 16'h0003);
    vecs[2] = mk(3'd7, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    vecs[3] = mk(3'd1, 16'hFFFF, 16'h0001, 16'h0, 16'h0, 16'h8000);
    vecs[4] = mk(3'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'h0000);
    vecs[5] = mk(3'd3, 16'd10, 16'd20, 16'd30, 16'd40, 16'h0019);
    vecs[6] = mk(3'd1, 16'd7, 16'd8, 16'h0, 16'h0, 16'h0007);
    vecs[7] = mk(3'd0, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0000);

    adc.busy = 1'b0;
    tick_n(3);
    check_output("reset_cnv_start", adc.cnv_start, 0);
    check_output("reset_avg_data", avg_data, 0);
    check_output("reset_avg_valid", avg_valid, 0);
    check_output("reset_active", active, 0);
    check_output("reset_overrun", overrun, 0);
    check_output("reset_timeout_err", timeout_err, 0);
    rst = 1'b0;
    tick_n(2);

    $display("[TB] periodic single-sample conversions");
    period = 16'd199; avg_log2 = 3'd0; valid_delay = 60; sb_auto = 1'b1;
    default_result = 16'h1234; start_cycles.delete();
    e = cyc;
    enable = 1'b1;
    wait_starts(3, 700, "periodic_starts");
    if (start_cycles.size() >= 3) begin
      check_output("first_start_cycle", start_cycles[0], e + 1);
      check_output("period_interval_1", start_cycles[1] - start_cycles[0], 200);
      check_output("period_interval_2", start_cycles[2] - start_cycles[1], 200);
    end
    check_output("periodic_overrun", overrun, 0);
    enable = 1'b0;
    tick_n(80);
    check_output("periodic_scoreboard_empty", sb_q.size(), 0);
    sb_auto = 1'b0;

    $display("[TB] averaging vector table");
    period = 16'd39; valid_delay = 10; default_result = 16'h0000;
    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i]);
    check_output("vectors_overrun", overrun, 0);

    $display("[TB] overrun on dropped ticks");
    avg_log2 = 3'd0; period = 16'd19; valid_delay = 60; sb_auto = 1'b1;
    default_result = 16'h0BEE; start_cycles.delete();
    enable = 1'b1;
    wait_starts(1, 10, "overrun_first_start");
    s = start_cycles.size() > 0 ? start_cycles[0] : cyc;
    t = s - 1;
    wait_cyc(t + 20);
    check_output("overrun_before_drop", overrun, 0);
    wait_cyc(t + 21);
    check_output("overrun_after_drop", overrun, 1);
    wait_cyc(t + 25);
    clr_err = 1'b1;
    wait_cyc(t + 26);
    clr_err = 1'b0;
    check_output("overrun_cleared", overrun, 0);
    wait_cyc(t + 40);
    check_output("overrun_still_clear", overrun, 0);
    wait_cyc(t + 41);
    check_output("overrun_reset_by_drop", overrun, 1);
    wait_starts(3, 200, "overrun_starts");
    if (start_cycles.size() >= 3) begin
      check_output("overrun_interval_1", start_cycles[1] - start_cycles[0], 80);
      check_output("overrun_interval_2", start_cycles[2] - start_cycles[1], 80);
    end
    enable = 1'b0;
    tick_n(80);
    sb_auto = 1'b0;
    pulse_clr();
    check_output("overrun_final_clear", overrun, 0);
    sb_q.delete();

    $display("[TB] timeout discards partial block");
    avg_log2 = 3'd2; period = 16'd1199; valid_delay = 10; mute = 1'b0;
    results_q.push_back(16'd100); results_q.push_back(16'd200);
    start_cycles.delete();
    seen0 = avg_seen;
    enable = 1'b1;
    wait_starts(2, 1300, "timeout_start_2");
    tick_n(20);
    mute = 1'b1;
    wait_starts(3, 1300, "timeout_start_3");
    s = start_cycles.size() >= 3 ? start_cycles[2] : cyc;
    wait_cyc(s + TIMEOUT);
    check_output("timeout_err_at_limit", timeout_err, 0);
    check_output("active_at_limit", active, 1);
    wait_cyc(s + TIMEOUT + 1);
    check_output("timeout_err_after_limit", timeout_err, 1);
    check_output("active_after_limit", active, 0);
    mute = 1'b0;
    results_q.push_back(16'd4); results_q.push_back(16'd8);
    results_q.push_back(16'd12); results_q.push_back(16'd16);
    sb_q.push_back(16'd10);
    wait_starts(4, 1300, "timeout_start_4");
    if (start_cycles.size() >= 4) check_output("start_after_timeout", start_cycles[3], s + 1200);
    wait_avg(seen0 + 1, 5000, "timeout_fresh_block");
    enable = 1'b0;
    tick_n(5);
    check_output("timeout_scoreboard_empty", sb_q.size(), 0);
    pulse_clr();
    check_output("timeout_err_cleared", timeout_err, 0);

    $display("[TB] single-shot requests");
    avg_log2 = 3'd0; valid_delay = 30; sb_auto = 1'b1; default_result = 16'h0C0D;
    start_cycles.delete(); results_q.delete();
    seen0 = avg_seen;
    e = cyc;
    single = 1'b1; tick_n(1); single = 1'b0;
    tick_n(9);
    single = 1'b1; tick_n(1); single = 1'b0;
    tick_n(40);
    check_output("single_start_count", start_cycles.size(), 1);
    if (start_cycles.size() >= 1) check_output("single_start_cycle", start_cycles[0], e + 1);
    check_output("single_in_wait_overrun", overrun, 0);
    check_output("single_avg_count", avg_seen, seen0 + 1);
    valid_delay = TIMEOUT;
    start_cycles.delete();
    single = 1'b1; tick_n(1); single = 1'b0;
    wait_avg(seen0 + 2, TIMEOUT + 100, "valid_at_timeout_limit");
    tick_n(2);
    check_output("valid_at_limit_no_timeout", timeout_err, 0);
    check_output("valid_at_limit_start_count", start_cycles.size(), 1);
    sb_auto = 1'b0;

    $display("[TB] busy interface drops ticks");
    adc.busy = 1'b1; period = 16'd9; valid_delay = 10;
    start_cycles.delete();
    enable = 1'b1;
    tick_n(15);
    check_output("busy_no_start", start_cycles.size(), 0);
    check_output("busy_overrun", overrun, 1);
    enable = 1'b0;
    adc.busy = 1'b0;
    tick_n(2);

    $display("[TB] reset during conversion");
    avg_log2 = 3'd0; valid_delay = 50; period = 16'd999; default_result = 16'h7777;
    start_cycles.delete();
    seen0 = avg_seen;
    enable = 1'b1;
    wait_starts(1, 10, "reset_test_start");
    s = start_cycles.size() > 0 ? start_cycles[0] : cyc;
    wait_cyc(s + 10);
    check_output("active_before_reset", active, 1);
    rst = 1'b1;
    enable = 1'b0;
    tick_n(2);
    check_output("mid_reset_cnv_start", adc.cnv_start, 0);
    check_output("mid_reset_avg_data", avg_data, 0);
    check_output("mid_reset_avg_valid", avg_valid, 0);
    check_output("mid_reset_active", active, 0);
    check_output("mid_reset_overrun", overrun, 0);
    check_output("mid_reset_timeout_err", timeout_err, 0);
    rst = 1'b0;
    wait_cyc(s + 60);
    check_output("late_valid_ignored", avg_seen, seen0);
    check_output("late_valid_active", active, 0);
    sb_auto = 1'b1; default_result = 16'h5A5A; valid_delay = 10;
    start_cycles.delete();
    enable = 1'b1;
    wait_avg(seen0 + 1, 100, "after_reset_avg");
    enable = 1'b0;
    tick_n(20);
    check_output("after_reset_start_count", start_cycles.size(), 1);
    check_output("after_reset_scoreboard_empty", sb_q.size(), 0);
    sb_auto = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
